conv_pool_sequencer: RTL and testbench
======================================

# conv_pool_sequencer

Frame-level controller that sequences the two-stage feature pipeline: it holds the convolution stage (`conv2`) and then the max-pooling stage (`maxpooling`) in reset, releases each in turn, and waits for each stage's `done`. It replaces the hand-driven reset/clock sequencing currently done per frame. It also exposes a host start/ack handshake, per-stage cycle counts and a per-stage watchdog.

## Interface
Parameters:
- `RST_CYCLES`, 2: cycles each stage's `nreset` is held low before release (≥1).
- `TIMEOUT`, 200000: maximum RUN cycles per stage before error (≥2).
- `CNT_W`, 20: width of the cycle counters and timeout counter.

Ports:
- `clock`  in  1: single clock; all state is updated on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: frame request. Sampled only in IDLE.
- `abort`  in  1: cancels any frame in progress.
- `conv_done`  in  1: `done` from the convolution stage.
- `pool_done`  in  1: `done` from the pooling stage.
- `frame_ack`  in  1: host acknowledges DONE or ERROR.
- `conv_nreset`  out  1: active-low reset to the convolution stage.
- `pool_nreset`  out  1: active-low reset to the pooling stage.
- `capture_conv`  out  1: one-cycle pulse; the convolution output is final.
- `busy`  out  1: high in every state except IDLE.
- `frame_valid`  out  1: high in DONE.
- `error`  out  1: high in ERROR.
- `error_stage`  out  2: 0 = none, 1 = conv timeout, 2 = pool timeout.
- `conv_cycles`  out  CNT_W: RUN cycles used by the convolution stage.
- `pool_cycles`  out  CNT_W: RUN cycles used by the pooling stage.

## Operation
- All outputs are registered.
- Reset values: every output is 0, so both stage resets are asserted. The FSM enters IDLE.
- FSM states: IDLE, CONV_RST, CONV_RUN, POOL_RST, POOL_RUN, DONE, ERROR.
- IDLE:
  - Both `nreset` outputs are 0.
  - On `start`=1, go to CONV_RST. Clear `conv_cycles`, `pool_cycles`, `error_stage` and the reset counter.
- CONV_RST:
  - `conv_nreset`=0 and `conv_done` is ignored (the value may be stale).
  - After RST_CYCLES edges, go to CONV_RUN with `conv_nreset`=1.
- CONV_RUN:
  - `conv_cycles` increments on every edge, including the edge that samples `conv_done`=1. It saturates at 2^CNT_W−1.
  - On `conv_done`=1: pulse `capture_conv` for 1 cycle and go to POOL_RST. `conv_nreset` stays 1 so the convolution output stays valid for pooling.
- POOL_RST and POOL_RUN follow the same rules using `pool_nreset`, `pool_done` and `pool_cycles`. `conv_nreset` stays 1 throughout.
- On `pool_done`=1, go to DONE.
- DONE:
  - `frame_valid`=1 and both `nreset` outputs stay 1, so the output arrays are held.
  - On `frame_ack`, go to IDLE.
- Timeout:
  - In a RUN state, if the stage's cycle count reaches TIMEOUT without `done`, go to ERROR.
  - `error_stage` is set to 1 (conv) or 2 (pool).
  - Both `nreset` outputs are 0 in ERROR.
  - On `frame_ack`, go to IDLE. `error` clears, but `error_stage` holds until the next `start`.
- Priorities:
  - `abort` (in any non-IDLE state) beats `done` and timeout. It goes to IDLE on the next edge; `frame_valid` and `error` are not asserted.
  - `done` beats timeout on the same edge.
  - `start` outside IDLE is ignored.
  - `frame_ack` outside DONE/ERROR is ignored.
  - `start` and `frame_ack` together in DONE: take `frame_ack` only; `start` must be re-presented in IDLE.
- Reset mid-frame: asynchronous return to IDLE with all outputs 0.

## Timing
- Let E0 be the edge that samples `start`=1.
- `conv_nreset` is 0 through E0+RST_CYCLES−1 and rises after edge E0+RST_CYCLES.
- `conv_done` first sampled at edge Ec:
  - `capture_conv` is high for the cycle after Ec.
  - `pool_nreset` rises after Ec+RST_CYCLES.
- `pool_done` sampled at edge Ep: `frame_valid` is high after Ep.
- Overhead beyond stage compute is 2·RST_CYCLES+1 edges plus the ack latency.
- `busy` rises after E0 and falls after the edge that samples `frame_ack` (or `abort`).

## Test plan
1. **Nominal frame.** RST_CYCLES=2. Pulse `start`; assert `conv_done` on the 5th CONV_RUN edge and `pool_done` on the 3rd POOL_RUN edge.
   - Required: `conv_nreset` rises 2 cycles after start.
   - Required: one `capture_conv` pulse.
   - Required: `conv_cycles`=5, `pool_cycles`=3, `frame_valid`=1 until `frame_ack`.
2. **Stale done.** Hold `conv_done`=1 and `pool_done`=1 from reset through the *_RST states.
   - Required: no transition out of CONV_RST before 2 edges.
   - Required: `conv_cycles`=1 (done is taken on the first RUN edge).
3. **Pool timeout.** TIMEOUT=10 and `pool_done` is never asserted.
   - Required: `error`=1, `error_stage`=2, `pool_cycles`=10, both `nreset`=0.
   - Required: `frame_ack` returns to IDLE with `error`=0.
4. **Abort.** Assert `abort` in CONV_RUN on the same edge as `conv_done`.
   - Required: IDLE next cycle, no `capture_conv`, `busy`=0, `frame_valid` never set.
5. **Ignored start and done/timeout tie.**
   - `start` during POOL_RUN is ignored.
   - `pool_done` on the edge where the count reaches TIMEOUT gives DONE, not ERROR.
6. **Asynchronous reset in DONE.** Pulse `reset` between clock edges.
   - Required: all outputs 0 immediately; next `start` runs a clean frame.

Source files
------------

// File: rtl/conv_pool_sequencer.sv
// -----------------------------------------------------------------------------
// conv_pool_sequencer
//
// Frame-level controller for the two-stage feature pipeline. It holds the
// convolution stage in reset, then releases it and waits for its done. It then
// does the same for the max-pooling stage. It also handles the host start/ack
// handshake, counts the RUN cycles of each stage, and runs a per-stage watchdog.
//
// Ports
//   clock, reset    : single rising-edge clock; asynchronous active-high reset
//   start           : frame request, only looked at in IDLE
//   abort           : cancels a frame in progress (any non-IDLE state)
//   conv_done       : done from the convolution stage
//   pool_done       : done from the pooling stage
//   frame_ack       : host acknowledge of DONE or ERROR
//   conv_nreset     : active-low reset to the convolution stage
//   pool_nreset     : active-low reset to the pooling stage
//   capture_conv    : one-cycle pulse; the convolution output is final
//   busy            : high in every state except IDLE
//   frame_valid     : high in DONE
//   error           : high in ERROR
//   error_stage     : 0 none, 1 conv timeout, 2 pool timeout
//   conv_cycles     : RUN cycles used by the convolution stage
//   pool_cycles     : RUN cycles used by the pooling stage
// -----------------------------------------------------------------------------
module conv_pool_sequencer #(
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 200000,
   parameter int CNT_W      = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             conv_done,
   input  logic             pool_done,
   input  logic             frame_ack,
   output logic             conv_nreset,
   output logic             pool_nreset,
   output logic             capture_conv,
   output logic             busy,
   output logic             frame_valid,
   output logic             error,
   output logic [1:0]       error_stage,
   output logic [CNT_W-1:0] conv_cycles,
   output logic [CNT_W-1:0] pool_cycles
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CONV_RST = 3'd1;
   localparam logic [2:0] S_CONV_RUN = 3'd2;
   localparam logic [2:0] S_POOL_RST = 3'd3;
   localparam logic [2:0] S_POOL_RUN = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_ERROR    = 3'd6;

   localparam int               RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic [2:0]       state_q, state_d;
   logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d, conv_inc_s;
   logic [CNT_W-1:0] pool_cnt_q, pool_cnt_d, pool_inc_s;
   logic [1:0]       err_stage_q, err_stage_d;
   logic             capture_d;
   logic             capture_q, conv_nreset_q, pool_nreset_q;
   logic             busy_q, frame_valid_q, error_q;

   // Saturating increments of the stage cycle counters.
   always_comb begin
      if (conv_cnt_q == CNT_MAX) begin
         conv_inc_s = conv_cnt_q;
      end else begin
         conv_inc_s = conv_cnt_q + CNT_W'(1);
      end
      if (pool_cnt_q == CNT_MAX) begin
         pool_inc_s = pool_cnt_q;
      end else begin
         pool_inc_s = pool_cnt_q + CNT_W'(1);
      end
   end

   // Next-state logic. Priority inside a RUN state: abort, then done, then timeout.
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      conv_cnt_d  = conv_cnt_q;
      pool_cnt_d  = pool_cnt_q;
      err_stage_d = err_stage_q;
      capture_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_CONV_RST;
               rst_cnt_d   = '0;
               conv_cnt_d  = '0;
               pool_cnt_d  = '0;
               err_stage_d = 2'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         // The stage done is deliberately ignored here because it can be stale.
         S_CONV_RST, S_POOL_RST: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (rst_cnt_q == RST_LAST) begin
               state_d = (state_q == S_CONV_RST) ? S_CONV_RUN : S_POOL_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         S_CONV_RUN: begin
            conv_cnt_d = conv_inc_s;
            if (abort) begin
               state_d = S_IDLE;
            end else if (conv_done) begin
               state_d   = S_POOL_RST;
               rst_cnt_d = '0;
               capture_d = 1'b1;
            end else if (conv_inc_s >= TIMEOUT_C) begin
               state_d     = S_ERROR;
               err_stage_d = 2'd1;
            end else begin
               state_d = S_CONV_RUN;
            end
         end
         S_POOL_RUN: begin
            pool_cnt_d = pool_inc_s;
            if (abort) begin
               state_d = S_IDLE;
            end else if (pool_done) begin
               state_d = S_DONE;
            end else if (pool_inc_s >= TIMEOUT_C) begin
               state_d     = S_ERROR;
               err_stage_d = 2'd2;
            end else begin
               state_d = S_POOL_RUN;
            end
         end
         // A start that arrives together with frame_ack is dropped on purpose.
         S_DONE, S_ERROR: begin
            if (abort || frame_ack) begin
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters and outputs. The outputs are decoded from the next state so
   // that each output register already shows the value for the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rst_cnt_q     <= '0;
         conv_cnt_q    <= '0;
         pool_cnt_q    <= '0;
         err_stage_q   <= 2'd0;
         capture_q     <= 1'b0;
         conv_nreset_q <= 1'b0;
         pool_nreset_q <= 1'b0;
         busy_q        <= 1'b0;
         frame_valid_q <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         conv_cnt_q    <= conv_cnt_d;
         pool_cnt_q    <= pool_cnt_d;
         err_stage_q   <= err_stage_d;
         capture_q     <= capture_d;
         conv_nreset_q <= (state_d == S_CONV_RUN) || (state_d == S_POOL_RST) ||
                          (state_d == S_POOL_RUN) || (state_d == S_DONE);
         pool_nreset_q <= (state_d == S_POOL_RUN) || (state_d == S_DONE);
         busy_q        <= (state_d != S_IDLE);
         frame_valid_q <= (state_d == S_DONE);
         error_q       <= (state_d == S_ERROR);
      end
   end

   assign conv_nreset  = conv_nreset_q;
   assign pool_nreset  = pool_nreset_q;
   assign capture_conv = capture_q;
   assign busy         = busy_q;
   assign frame_valid  = frame_valid_q;
   assign error        = error_q;
   assign error_stage  = err_stage_q;
   assign conv_cycles  = conv_cnt_q;
   assign pool_cycles  = pool_cnt_q;

endmodule

// File: tb/tb_conv_pool_sequencer.sv
module tb_conv_pool_sequencer;

   localparam int RST = 2;
   localparam int TMO = 10;
   localparam int CW  = 20;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          conv_done = 1'b0;
   logic          pool_done = 1'b0;
   logic          frame_ack = 1'b0;
   logic          conv_nreset, pool_nreset, capture_conv, busy, frame_valid, error;
   logic [1:0]    error_stage;
   logic [CW-1:0] conv_cycles, pool_cycles;

   int n_checks = 0;
   int n_errors = 0;
   int cap_seen = 0;

   conv_pool_sequencer #(.RST_CYCLES(RST), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .conv_done(conv_done), .pool_done(pool_done), .frame_ack(frame_ack),
      .conv_nreset(conv_nreset), .pool_nreset(pool_nreset),
      .capture_conv(capture_conv), .busy(busy), .frame_valid(frame_valid),
      .error(error), .error_stage(error_stage),
      .conv_cycles(conv_cycles), .pool_cycles(pool_cycles)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_CRST, M_CRUN, M_PRST, M_PRUN, M_DONE, M_ERR} mph_t;
   mph_t m_ph = M_IDLE;
   int   m_rst_left = 0;
   int   m_cc = 0;
   int   m_pc = 0;
   int   m_es = 0;
   bit   m_cap = 1'b0;
   localparam int MAXC = (1 << CW) - 1;

   task automatic model_step();
      if (reset) begin
         m_ph = M_IDLE; m_cc = 0; m_pc = 0; m_es = 0; m_cap = 1'b0; m_rst_left = 0;
      end else begin
         m_cap = 1'b0;
         case (m_ph)
            M_IDLE: if (start) begin
               m_ph = M_CRST; m_rst_left = RST; m_cc = 0; m_pc = 0; m_es = 0;
            end
            M_CRST, M_PRST: if (abort) m_ph = M_IDLE;
               else begin
                  m_rst_left--;
                  if (m_rst_left == 0) m_ph = (m_ph == M_CRST) ? M_CRUN : M_PRUN;
               end
            M_CRUN: begin
               if (m_cc < MAXC) m_cc++;
               if (abort) m_ph = M_IDLE;
               else if (conv_done) begin m_cap = 1'b1; m_ph = M_PRST; m_rst_left = RST; end
               else if (m_cc >= TMO) begin m_ph = M_ERR; m_es = 1; end
            end
            M_PRUN: begin
               if (m_pc < MAXC) m_pc++;
               if (abort) m_ph = M_IDLE;
               else if (pool_done) m_ph = M_DONE;
               else if (m_pc >= TMO) begin m_ph = M_ERR; m_es = 2; end
            end
            M_DONE, M_ERR: if (abort || frame_ack) m_ph = M_IDLE;
            default: m_ph = M_IDLE;
         endcase
      end
   endtask

   initial forever begin
      @(posedge clock or posedge reset);
      model_step();
   end

   // Compare every output against the model on each falling edge.
   initial forever begin
      @(negedge clock);
      chk("conv_nreset", 64'(conv_nreset), 64'(m_ph inside {M_CRUN, M_PRST, M_PRUN, M_DONE}));
      chk("pool_nreset", 64'(pool_nreset), 64'(m_ph inside {M_PRUN, M_DONE}));
      chk("busy", 64'(busy), 64'(m_ph != M_IDLE));
      chk("frame_valid", 64'(frame_valid), 64'(m_ph == M_DONE));
      chk("error", 64'(error), 64'(m_ph == M_ERR));
      chk("capture_conv", 64'(capture_conv), 64'(m_cap));
      chk("error_stage", 64'(error_stage), 64'(m_es));
      chk("conv_cycles", 64'(conv_cycles), 64'(m_cc));
      chk("pool_cycles", 64'(pool_cycles), 64'(m_pc));
   end

   // ---------------- directed helpers with literal expectations ----------------
   task automatic adv();
      @(negedge clock);
      cap_seen += int'(capture_conv);
   endtask

   task automatic run_frame(input int cn, input int pn, input bit stale, input bit do_ack);
      cap_seen = 0;
      conv_done = stale; pool_done = stale;
      start = 1'b1; adv(); start = 1'b0;
      chk("f_busy_e0", 64'(busy), 64'd1);
      chk("f_cnr_e0", 64'(conv_nreset), 64'd0);
      adv();
      chk("f_cnr_e1", 64'(conv_nreset), 64'd0);
      adv();
      chk("f_cnr_e2", 64'(conv_nreset), 64'd1);
      for (int i = 1; i <= cn; i++) begin
         conv_done = (i == cn);
         adv();
      end
      conv_done = 1'b0;
      chk("f_capture", 64'(capture_conv), 64'd1);
      chk("f_conv_cycles", 64'(conv_cycles), 64'(cn));
      adv();
      chk("f_pnr_r1", 64'(pool_nreset), 64'd0);
      chk("f_cnr_held", 64'(conv_nreset), 64'd1);
      adv();
      chk("f_pnr_r2", 64'(pool_nreset), 64'd1);
      for (int i = 1; i <= pn; i++) begin
         pool_done = (i == pn);
         adv();
      end
      pool_done = 1'b0;
      chk("f_frame_valid", 64'(frame_valid), 64'd1);
      chk("f_pool_cycles", 64'(pool_cycles), 64'(pn));
      chk("f_error", 64'(error), 64'd0);
      repeat (3) adv();
      chk("f_valid_hold", 64'(frame_valid), 64'd1);
      chk("f_cap_count", 64'(cap_seen), 64'd1);
      if (do_ack) begin
         frame_ack = 1'b1; adv(); frame_ack = 1'b0;
         chk("f_ack_busy", 64'(busy), 64'd0);
         chk("f_ack_valid", 64'(frame_valid), 64'd0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cnr", 64'(conv_nreset), 64'd0);
      chk("rst_cycles", 64'(conv_cycles), 64'd0);
      reset = 1'b0;
      adv();

      // Nominal frame and stale-done frame.
      run_frame(5, 3, 1'b0, 1'b1);
      run_frame(1, 1, 1'b1, 1'b1);

      // Pool timeout.
      start = 1'b1; adv(); start = 1'b0;
      adv(); adv();
      conv_done = 1'b1; adv(); conv_done = 1'b0;
      adv(); adv();
      repeat (TMO - 1) adv();
      chk("to_not_yet", 64'(error), 64'd0);
      adv();
      chk("to_error", 64'(error), 64'd1);
      chk("to_stage", 64'(error_stage), 64'd2);
      chk("to_pool_cycles", 64'(pool_cycles), 64'd10);
      chk("to_cnr", 64'(conv_nreset), 64'd0);
      chk("to_pnr", 64'(pool_nreset), 64'd0);
      frame_ack = 1'b1; adv(); frame_ack = 1'b0;
      chk("to_ack_error", 64'(error), 64'd0);
      chk("to_ack_stage", 64'(error_stage), 64'd2);
      chk("to_ack_busy", 64'(busy), 64'd0);

      // Abort together with conv_done.
      cap_seen = 0;
      start = 1'b1; adv(); start = 1'b0;
      repeat (4) adv();
      abort = 1'b1; conv_done = 1'b1; adv(); abort = 1'b0; conv_done = 1'b0;
      chk("ab_busy", 64'(busy), 64'd0);
      chk("ab_valid", 64'(frame_valid), 64'd0);
      adv();
      chk("ab_caps", 64'(cap_seen), 64'd0);
      chk("ab_stage", 64'(error_stage), 64'd0);

      // Ignored start in POOL_RUN, done/timeout tie, start with ack in DONE.
      start = 1'b1; adv(); start = 1'b0;
      adv(); adv();
      conv_done = 1'b1; adv(); conv_done = 1'b0;
      adv(); adv();
      for (int i = 1; i < TMO; i++) begin
         start = (i == 3);
         adv();
      end
      start = 1'b0;
      pool_done = 1'b1; adv(); pool_done = 1'b0;
      chk("tie_valid", 64'(frame_valid), 64'd1);
      chk("tie_error", 64'(error), 64'd0);
      chk("tie_pool_cycles", 64'(pool_cycles), 64'd10);
      start = 1'b1; frame_ack = 1'b1; adv(); start = 1'b0; frame_ack = 1'b0;
      chk("sa_busy", 64'(busy), 64'd0);
      adv();
      chk("sa_no_restart", 64'(busy), 64'd0);

      // Asynchronous reset while in DONE, then a clean frame.
      run_frame(4, 2, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", 64'(frame_valid), 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_cnr", 64'(conv_nreset), 64'd0);
      chk("ar_pnr", 64'(pool_nreset), 64'd0);
      chk("ar_cycles", 64'(conv_cycles), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      adv();
      run_frame(3, 4, 1'b0, 1'b1);

      // Randomized traffic, checked by the model on every cycle.
      for (int c = 0; c < 4000; c++) begin
         start     = ($urandom_range(0, 99) < 30);
         abort     = ($urandom_range(0, 99) < 3);
         conv_done = ($urandom_range(0, 99) < 15);
         pool_done = ($urandom_range(0, 99) < 15);
         frame_ack = ($urandom_range(0, 99) < 30);
         adv();
      end
      start = 1'b0; abort = 1'b0; conv_done = 1'b0; pool_done = 1'b0; frame_ack = 1'b0;
      adv();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
